// File: rtl/mem_access_unit_pkg.sv
// Shared load/store encodings and the small helpers used to size, align and
// lane-place a memory access.
package mem_access_unit_pkg;

    localparam logic [1:0] MEM_B = 2'd0;
    localparam logic [1:0] MEM_H = 2'd1;
    localparam logic [1:0] MEM_W = 2'd2;

    localparam logic [2:0] LX_LB  = 3'd0;
    localparam logic [2:0] LX_LH  = 3'd1;
    localparam logic [2:0] LX_LW  = 3'd2;
    localparam logic [2:0] LX_LBU = 3'd3;
    localparam logic [2:0] LX_LHU = 3'd4;

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DONE, ST_ERR} state_t;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

    // Stores take their width from mem_ctrl, loads from the extend select.
    function automatic size_t access_size(input logic we, input logic [1:0] mem_ctrl,
                                          input logic [2:0] lx);
        size_t sz;
        sz = SZ_W;
        if (we) begin
            case (mem_ctrl)
                MEM_B:   sz = SZ_B;
                MEM_H:   sz = SZ_H;
                default: sz = SZ_W;
            endcase
        end else begin
            case (lx)
                LX_LB, LX_LBU: sz = SZ_B;
                LX_LH, LX_LHU: sz = SZ_H;
                default:       sz = SZ_W;
            endcase
        end
        return sz;
    endfunction

    function automatic logic misaligned(input size_t sz, input logic [1:0] off);
        logic m;
        case (sz)
            SZ_H:    m = off[0];
            SZ_W:    m = |off;
            default: m = 1'b0;
        endcase
        return m;
    endfunction

    function automatic logic [3:0] byte_en(input size_t sz, input logic [1:0] off);
        logic [3:0] be;
        case (sz)
            SZ_B:    be = 4'b0001 << off;
            SZ_H:    be = 4'b0011 << off;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] lane_rep(input size_t sz, input logic [31:0] d);
        logic [31:0] r;
        case (sz)
            SZ_B:    r = {4{d[7:0]}};
            SZ_H:    r = {2{d[15:0]}};
            default: r = d;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// Picks the addressed byte/half out of a memory word and sign- or zero-extends it.
module mem_access_unit_load_extend
    import mem_access_unit_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [2:0]  sel,
    output logic [31:0] result
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    assign lane_b = word[{offset, 3'b000} +: 8];
    assign lane_h = offset[1] ? word[31:16] : word[15:0];

    always_comb begin
        result = word;
        case (sel)
            LX_LB:   result = {{24{lane_b[7]}}, lane_b};
            LX_LH:   result = {{16{lane_h[15]}}, lane_h};
            LX_LBU:  result = {24'd0, lane_b};
            LX_LHU:  result = {16'd0, lane_h};
            default: result = word;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit: turns one memory-phase request into a single word-aligned
// data-memory transaction and returns extended load data with a done strobe.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        mem_ctrl,
    input  logic [2:0]        load_extend_sel,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              done,
    output logic              err,
    output logic              busy,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [3:0]        m_be,
    output logic [31:0]       m_wdata,
    input  logic [31:0]       m_rdata,
    input  logic              m_ready
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t             state, state_nxt;
    logic               we_q;
    logic [2:0]         lx_q;
    logic [1:0]         off_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [3:0]         be_q;
    logic [31:0]        wdata_q;
    logic [CNT_W-1:0]   cnt;
    logic [31:0]        ld_val;
    size_t              sz_in;
    logic               mis_in;
    logic               tmo;

    assign sz_in  = access_size(we, mem_ctrl, load_extend_sel);
    assign mis_in = misaligned(sz_in, addr[1:0]);
    // Last wait cycle before giving up; a zero TIMEOUT never fires.
    assign tmo    = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1));

    mem_access_unit_load_extend u_ext (
        .word   (m_rdata),
        .offset (off_q),
        .sel    (lx_q),
        .result (ld_val)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (req) state_nxt = mis_in ? ST_ERR : ST_ISSUE;
            ST_ISSUE: begin
                if (m_ready)  state_nxt = ST_DONE;
                else if (tmo) state_nxt = ST_ERR;
            end
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            we_q    <= 1'b0;
            lx_q    <= '0;
            off_q   <= '0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            cnt     <= '0;
            rdata   <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && req) begin
                we_q    <= we;
                lx_q    <= load_extend_sel;
                off_q   <= addr[1:0];
                addr_q  <= {addr[ADDR_W-1:2], 2'b00};
                be_q    <= byte_en(sz_in, addr[1:0]);
                wdata_q <= lane_rep(sz_in, wdata);
            end
            if (state == ST_ISSUE && !m_ready) cnt <= cnt + 1'b1;
            else                               cnt <= '0;
            if (state == ST_ISSUE && m_ready && !we_q) rdata <= ld_val;
        end
    end

    assign m_req   = (state == ST_ISSUE);
    assign m_we    = m_req & we_q;
    assign m_addr  = addr_q;
    assign m_be    = be_q;
    assign m_wdata = wdata_q;
    assign done    = (state == ST_DONE) || (state == ST_ERR);
    assign err     = (state == ST_ERR);
    assign busy    = (state != ST_IDLE);

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed vector table, reset/busy sequences and
// randomized accesses against an arithmetic reference model.
module tb_mem_access_unit;

    localparam int ADDR_W  = 32;
    localparam int TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              req, we, m_ready;
    logic [1:0]        mem_ctrl;
    logic [2:0]        load_extend_sel;
    logic [ADDR_W-1:0] addr, m_addr;
    logic [31:0]       wdata, rdata, m_wdata, m_rdata;
    logic              done, err, busy, m_req, m_we;
    logic [3:0]        m_be;

    mem_access_unit #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .mem_ctrl(mem_ctrl),
        .load_extend_sel(load_extend_sel), .addr(addr), .wdata(wdata),
        .rdata(rdata), .done(done), .err(err), .busy(busy), .m_req(m_req),
        .m_we(m_we), .m_addr(m_addr), .m_be(m_be), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ready(m_ready)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    typedef struct {
        logic        w;
        logic [1:0]  mc;
        logic [2:0]  sel;
        logic [31:0] a, wd, mw;
        int          waits;
        logic [3:0]  be;
        logic [31:0] ewd;
        int          lat, nreq;
        logic        eerr;
        logic [31:0] rd;
    } vec_t;

    // One complete access: memory answers after `waits` m_req cycles; lat counts
    // cycles from the req cycle to the done cycle.
    task automatic run_access(input vec_t v);
        int   nreq, lat;
        logic got_err;
        nreq = 0; lat = 0; got_err = 1'b0;
        @(negedge clk);
        req = 1'b1; we = v.w; mem_ctrl = v.mc; load_extend_sel = v.sel;
        addr = v.a; wdata = v.wd; m_rdata = v.mw; m_ready = 1'b0;
        @(negedge clk);
        req = 1'b0; we = ~v.w; addr = $urandom; wdata = $urandom;
        for (int k = 1; k <= 60; k++) begin
            if (k > 1) @(negedge clk);
            if (k == 1) chk("busy_in_flight", {31'd0, busy}, 32'd1);
            if (done) begin
                lat = k; got_err = err;
                break;
            end
            if (m_req) begin
                nreq++;
                chk("m_addr", m_addr, v.a & 32'hFFFF_FFFC);
                chk("m_be", {28'd0, m_be}, {28'd0, v.be});
                chk("m_wdata", m_wdata, v.ewd);
                chk("m_we", {31'd0, m_we}, {31'd0, v.w});
                m_ready = (nreq > v.waits);
            end else begin
                m_ready = 1'($urandom_range(0, 1));
            end
        end
        m_ready = 1'b0;
        chk("latency", lat, v.lat);
        chk("m_req_cycles", nreq, v.nreq);
        chk("err", {31'd0, got_err}, {31'd0, v.eerr});
        @(negedge clk);
        chk("done_one_cycle", {31'd0, done}, 32'd0);
        chk("busy_after", {31'd0, busy}, 32'd0);
        chk("rdata", rdata, v.rd);
    endtask

    vec_t        tbl[11];
    vec_t        rv;
    logic [31:0] rd_model, lane, val;
    int          bytes, nreq, ndone;
    logic        mis;

    initial begin
        tbl[0]  = '{1'b1, 2'd0, 3'd0, 32'h1003, 32'hA5, 32'h0, 0, 4'b1000, 32'hA5A5A5A5, 2, 1, 1'b0, 32'h0};
        tbl[1]  = '{1'b0, 2'd0, 3'd0, 32'h2001, 32'h0, 32'h1234F0CC, 0, 4'b0010, 32'h0, 2, 1, 1'b0, 32'hFFFFFFF0};
        tbl[2]  = '{1'b0, 2'd0, 3'd3, 32'h2001, 32'h0, 32'h1234F0CC, 0, 4'b0010, 32'h0, 2, 1, 1'b0, 32'h000000F0};
        tbl[3]  = '{1'b0, 2'd0, 3'd1, 32'h2002, 32'h0, 32'h80001111, 0, 4'b1100, 32'h0, 2, 1, 1'b0, 32'hFFFF8000};
        tbl[4]  = '{1'b0, 2'd0, 3'd4, 32'h2002, 32'h0, 32'h80001111, 0, 4'b1100, 32'h0, 2, 1, 1'b0, 32'h00008000};
        tbl[5]  = '{1'b0, 2'd0, 3'd2, 32'h2000, 32'h0, 32'h80001111, 0, 4'b1111, 32'h0, 2, 1, 1'b0, 32'h80001111};
        tbl[6]  = '{1'b1, 2'd2, 3'd2, 32'h3002, 32'h55, 32'h0, 0, 4'b0000, 32'h0, 1, 0, 1'b1, 32'h80001111};
        tbl[7]  = '{1'b0, 2'd0, 3'd1, 32'h3001, 32'h0, 32'h12345678, 0, 4'b0000, 32'h0, 1, 0, 1'b1, 32'h80001111};
        tbl[8]  = '{1'b1, 2'd1, 3'd2, 32'h4002, 32'h1234BEEF, 32'h0, 5, 4'b1100, 32'hBEEFBEEF, 7, 6, 1'b0, 32'h80001111};
        tbl[9]  = '{1'b0, 2'd0, 3'd2, 32'h0040, 32'h0, 32'hDEADBEEF, 3, 4'b1111, 32'h0, 5, 4, 1'b0, 32'hDEADBEEF};
        tbl[10] = '{1'b0, 2'd0, 3'd2, 32'h0050, 32'h0, 32'h0, 100, 4'b1111, 32'h0, TIMEOUT + 1, TIMEOUT, 1'b1, 32'hDEADBEEF};

        rst = 1'b0; req = 1'b0; we = 1'b0; mem_ctrl = '0; load_extend_sel = '0;
        addr = '0; wdata = '0; m_rdata = '0; m_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_m_req", {31'd0, m_req}, 32'd0);
        chk("rst_m_be", {28'd0, m_be}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        rst = 1'b1;

        foreach (tbl[i]) run_access(tbl[i]);

        // Reset in the middle of a waiting load.
        @(negedge clk);
        req = 1'b1; we = 1'b0; load_extend_sel = 3'd2; addr = 32'h6000; m_ready = 1'b0;
        @(negedge clk);
        req = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_rst_m_req", {31'd0, m_req}, 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("arst_m_req", {31'd0, m_req}, 32'd0);
        chk("arst_m_we", {31'd0, m_we}, 32'd0);
        chk("arst_m_addr", m_addr, 32'd0);
        chk("arst_m_wdata", m_wdata, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_done", {31'd0, done | err}, 32'd0);
        chk("arst_rdata", rdata, 32'd0);
        #1 rst = 1'b1;
        ndone = 0;
        repeat (6) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("post_rst_no_done", ndone, 0);
        chk("post_rst_idle", {31'd0, busy}, 32'd0);
        rd_model = 32'd0;

        // A req while busy, and a req in the done cycle, must both be dropped.
        @(negedge clk);
        req = 1'b1; we = 1'b1; mem_ctrl = 2'd2; addr = 32'h7000; wdata = 32'h11223344;
        @(negedge clk);
        req = 1'b0; nreq = 0; ndone = 0;
        for (int k = 1; k <= 20; k++) begin
            if (k > 1) @(negedge clk);
            if (m_req) begin
                nreq++;
                chk("busy_req_addr", m_addr, 32'h7000);
                m_ready = (nreq > 4);
            end else begin
                m_ready = 1'b0;
            end
            if (done) ndone++;
            req  = (k == 2) || (done === 1'b1);
            addr = done ? 32'h7200 : 32'h7100;
        end
        req = 1'b0;
        chk("busy_req_cycles", nreq, 5);
        chk("busy_req_dones", ndone, 1);

        // Randomized accesses against the reference model.
        for (int i = 0; i < 200; i++) begin
            rv.w   = 1'($urandom_range(0, 1));
            rv.mc  = 2'($urandom_range(0, 3));
            rv.sel = 3'($urandom_range(0, 7));
            rv.a   = $urandom;
            rv.wd  = $urandom;
            rv.mw  = $urandom;
            rv.waits = ($urandom_range(0, 7) == 0) ? 5 : $urandom_range(0, 2);
            if (rv.w) bytes = (rv.mc == 0) ? 1 : (rv.mc == 1) ? 2 : 4;
            else      bytes = (rv.sel == 0 || rv.sel == 3) ? 1 :
                              (rv.sel == 1 || rv.sel == 4) ? 2 : 4;
            mis = (rv.a % bytes) != 0;
            rv.be  = 4'(((1 << bytes) - 1) << (rv.a % 4));
            rv.ewd = (bytes == 1) ? (rv.wd & 32'hFF) * 32'h01010101 :
                     (bytes == 2) ? (rv.wd & 32'hFFFF) * 32'h00010001 : rv.wd;
            if (!mis && !rv.w) begin
                lane = rv.mw >> (8 * (rv.a % 4));
                if (bytes == 1) begin
                    val = lane & 32'hFF;
                    if (rv.sel == 0 && val >= 128) val = val - 32'd256;
                end else if (bytes == 2) begin
                    val = lane & 32'hFFFF;
                    if (rv.sel == 1 && val >= 32768) val = val - 32'd65536;
                end else begin
                    val = rv.mw;
                end
                rd_model = val;
            end
            rv.rd   = rd_model;
            rv.eerr = mis;
            rv.lat  = mis ? 1 : rv.waits + 2;
            rv.nreq = mis ? 0 : rv.waits + 1;
            run_access(rv);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
